// File: rtl/seg_pkg.sv
// Shared constants for the seg_scan_timer slice: 7-segment patterns ({g,f,e,d,c,b,a},
// active-high), FSM state encodings and the BCD increment helper.
package seg_pkg;

   localparam logic [6:0] SEG_0   = 7'h3F;
   localparam logic [6:0] SEG_1   = 7'h06;
   localparam logic [6:0] SEG_2   = 7'h5B;
   localparam logic [6:0] SEG_3   = 7'h4F;
   localparam logic [6:0] SEG_4   = 7'h66;
   localparam logic [6:0] SEG_5   = 7'h6D;
   localparam logic [6:0] SEG_6   = 7'h7D;
   localparam logic [6:0] SEG_7   = 7'h07;
   localparam logic [6:0] SEG_8   = 7'h7F;
   localparam logic [6:0] SEG_9   = 7'h6F;
   localparam logic [6:0] SEG_OFF = 7'h00;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;

   // Four-digit BCD +1 with per-digit ripple; 9999 wraps to 0000.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int unsigned i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = '0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD digit to active-high 7-segment pattern; blank or codes 10-15 give all-off.
module bcd_to_seg7
   import seg_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] pattern
);

   always_comb begin
      pattern = SEG_OFF;
      if (!blank) begin
         case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_OFF;
         endcase
      end
   end

endmodule

// File: rtl/seg_scan_timer.sv
// Four-digit BCD run/pause timer with multiplexed 7-segment scan, all in the sysclk domain.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits d3..d1.
module seg_scan_timer
   import seg_pkg::*;
#(
   parameter bit SEG_ACT_LOW = 1'b0,
   parameter bit AN_ACT_LOW  = 1'b0
) (
   input  logic        sysclk,
   input  logic        rst,
   input  logic        clk_1,
   input  logic        clk_1k,
   input  logic        start_stop,
   input  logic        clr,
   output logic [15:0] value,
   output logic        running,
   output logic        ovf,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   logic       clk_1_d;
   logic       clk_1k_d;
   logic       tick_1;
   logic       tick_1k;
   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       count_en;
   logic [1:0] scan_idx;
   logic [3:0] digit;
   logic       blank;
   logic [6:0] pattern;

   assign tick_1   = clk_1 & ~clk_1_d;
   assign tick_1k  = clk_1k & ~clk_1k_d;
   assign running  = (state == ST_RUN);
   assign count_en = (state == ST_RUN) && tick_1 && !clr;

   always_comb begin
      state_nxt = state;
      if (clr) begin
         state_nxt = ST_IDLE;
      end else if (start_stop) begin
         case (state)
            ST_IDLE:  state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_PAUSE;
            ST_PAUSE: state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      case (scan_idx)
         2'd0:    digit = value[3:0];
         2'd1:    digit = value[7:4];
         2'd2:    digit = value[11:8];
         default: digit = value[15:12];
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic lead3;
   logic lead2;
   logic lead1;
   // A digit is blank only when it and every digit above it are zero; d0 always shows.
   assign lead3 = (value[15:12] == 4'd0);
   assign lead2 = lead3 && (value[11:8] == 4'd0);
   assign lead1 = lead2 && (value[7:4] == 4'd0);
   always_comb begin
      case (scan_idx)
         2'd3:    blank = lead3;
         2'd2:    blank = lead2;
         2'd1:    blank = lead1;
         default: blank = 1'b0;
      endcase
   end
`else
   assign blank = 1'b0;
`endif

   bcd_to_seg7 u_dec (
      .bcd     (digit),
      .blank   (blank),
      .pattern (pattern)
   );

   always_ff @(posedge sysclk or negedge rst) begin
      if (!rst) begin
         clk_1_d  <= 1'b0;
         clk_1k_d <= 1'b0;
         state    <= ST_IDLE;
         value    <= '0;
         ovf      <= 1'b0;
         scan_idx <= '0;
         an       <= 4'b0001 ^ {4{AN_ACT_LOW}};
         seg      <= SEG_0 ^ {7{SEG_ACT_LOW}};
      end else begin
         clk_1_d  <= clk_1;
         clk_1k_d <= clk_1k;
         state    <= state_nxt;
         ovf      <= count_en && (value == 16'h9999);
         if (clr) begin
            value <= '0;
         end else if (count_en) begin
            value <= bcd_inc(value);
         end
         if (tick_1k) begin
            scan_idx <= scan_idx + 2'd1;
         end
         an  <= (4'b0001 << scan_idx) ^ {4{AN_ACT_LOW}};
         seg <= pattern ^ {7{SEG_ACT_LOW}};
      end
   end

endmodule

// File: tb/tb_seg_scan_timer.sv
// Directed-vector bench for seg_scan_timer (default polarity); honours LEADING_ZERO_BLANK_EN.
module tb_seg_scan_timer;

   logic        sysclk = 1'b0;
   logic        rst = 1'b0;
   logic        clk_1 = 1'b0;
   logic        clk_1k = 1'b0;
   logic        start_stop = 1'b0;
   logic        clr = 1'b0;
   logic [15:0] value;
   logic        running;
   logic        ovf;
   logic [3:0]  an;
   logic [6:0]  seg;

   int unsigned vectors = 0;
   int unsigned miscompares = 0;
   logic        ovf_seen;

   seg_scan_timer #(.SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)) dut (
      .sysclk     (sysclk),
      .rst        (rst),
      .clk_1      (clk_1),
      .clk_1k     (clk_1k),
      .start_stop (start_stop),
      .clr        (clr),
      .value      (value),
      .running    (running),
      .ovf        (ovf),
      .an         (an),
      .seg        (seg)
   );

   always #5 sysclk = ~sysclk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge sysclk);
      #1;
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1;
      step();
      start_stop = 1'b0;
   endtask

   // One clk_1 rising edge; ovf_seen captures ovf right after the counting edge.
   task automatic tick1(input int unsigned n);
      for (int unsigned k = 0; k < n; k++) begin
         clk_1 = 1'b1;
         step();
         ovf_seen = ovf;
         clk_1 = 1'b0;
         step();
      end
   endtask

   logic [3:0] an_exp [0:3];
   logic [6:0] seg_exp [0:3];

   initial begin
      an_exp[0] = 4'b0001; an_exp[1] = 4'b0010; an_exp[2] = 4'b0100; an_exp[3] = 4'b1000;
      seg_exp[0] = 7'h5B;
      seg_exp[1] = 7'h66;
`ifdef LEADING_ZERO_BLANK_EN
      seg_exp[2] = 7'h00;
      seg_exp[3] = 7'h00;
`else
      seg_exp[2] = 7'h3F;
      seg_exp[3] = 7'h3F;
`endif

      // reset state
      step();
      check("rst_value", value, 16'h0000);
      check("rst_running", 16'(running), 16'h0);
      check("rst_ovf", 16'(ovf), 16'h0);
      check("rst_an", 16'(an), 16'h0001);
      check("rst_seg", 16'(seg), 16'h003F);
      rst = 1'b1;
      step();

      // basic counting
      tick1(3);
      check("idle_no_count", value, 16'h0000);
      pulse_ss();
      check("start_running", 16'(running), 16'h1);
      tick1(12);
      check("count_12", value, 16'h0012);
      check("count_12_running", 16'(running), 16'h1);

      // ripple carries and wrap
      tick1(987);
      check("count_0999", value, 16'h0999);
      tick1(1);
      check("ripple_1000", value, 16'h1000);
      check("ripple_no_ovf", 16'(ovf_seen), 16'h0);
      tick1(8999);
      check("count_9999", value, 16'h9999);
      clk_1 = 1'b1;
      step();
      check("wrap_value", value, 16'h0000);
      check("wrap_ovf", 16'(ovf), 16'h1);
      clk_1 = 1'b0;
      step();
      check("wrap_ovf_one_cycle", 16'(ovf), 16'h0);

      // start_stop coincident with tick in RUN
      tick1(5);
      check("count_0005", value, 16'h0005);
      start_stop = 1'b1;
      clk_1 = 1'b1;
      step();
      start_stop = 1'b0;
      clk_1 = 1'b0;
      check("ss_tick_value", value, 16'h0006);
      check("ss_tick_paused", 16'(running), 16'h0);
      step();
      tick1(3);
      check("paused_hold", value, 16'h0006);

      // clr coincident with tick in RUN
      pulse_ss();
      check("resume_running", 16'(running), 16'h1);
      tick1(1);
      check("resume_count", value, 16'h0007);
      clr = 1'b1;
      clk_1 = 1'b1;
      step();
      clr = 1'b0;
      clk_1 = 1'b0;
      check("clr_value", value, 16'h0000);
      check("clr_idle", 16'(running), 16'h0);
      check("clr_ovf", 16'(ovf), 16'h0);
      step();
      tick1(1);
      check("clr_next_tick", value, 16'h0000);

      // digit scan with value 0042
      pulse_ss();
      tick1(42);
      pulse_ss();
      check("scan_value", value, 16'h0042);
      check("scan_an_init", 16'(an), 16'(an_exp[0]));
      check("scan_seg_init", 16'(seg), 16'(seg_exp[0]));
      for (int unsigned k = 0; k < 5; k++) begin
         clk_1k = 1'b1;
         step();
         check("scan_an_lag", 16'(an), 16'(an_exp[k % 4]));
         step();
         clk_1k = 1'b0;
         check("scan_an", 16'(an), 16'(an_exp[(k + 1) % 4]));
         check("scan_seg", 16'(seg), 16'(seg_exp[(k + 1) % 4]));
         step();
      end

      // asynchronous reset mid-count
      pulse_ss();
      tick1(315);
      check("pre_rst_value", value, 16'h0357);
      check("pre_rst_running", 16'(running), 16'h1);
      #2;
      rst = 1'b0;
      #1;
      check("async_value", value, 16'h0000);
      check("async_running", 16'(running), 16'h0);
      check("async_ovf", 16'(ovf), 16'h0);
      check("async_an", 16'(an), 16'h0001);
      check("async_seg", 16'(seg), 16'h003F);
      step();
      rst = 1'b1;
      step();
      tick1(3);
      check("post_rst_idle", value, 16'h0000);
      pulse_ss();
      tick1(1);
      check("post_rst_count", value, 16'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
